// File: rtl/cmd_encoder.sv
// cmd_encoder: builds a byte packet PREFIX, AST_ADDR, dest, len, payload[len]
// and, when CMD_ENCODER_CHECKSUM_EN is defined, a trailing 8-bit checksum
// (modulo-256 sum of the payload bytes only).
// A single output register (tx_data/tx_valid) carries every byte. Payload
// bytes are only accepted while that register is empty, so the source and
// the sink may each stall indefinitely without a byte being lost or repeated.
// All outputs come straight from flops.
module cmd_encoder #(
  parameter logic [7:0] PREFIX   = 8'hDD,
  parameter logic [7:0] AST_ADDR = 8'h01
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] dest,
  input  logic [7:0] len,
  output logic       busy,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREFIX = 3'd1,
    S_ADDR   = 3'd2,
    S_DEST   = 3'd3,
    S_LEN    = 3'd4,
`ifdef CMD_ENCODER_CHECKSUM_EN
    S_DATA   = 3'd5,
    S_CSUM   = 3'd6
`else
    S_DATA   = 3'd5
`endif
  } state_t;

`ifdef CMD_ENCODER_CHECKSUM_EN
  // Running checksum: 8-bit add, carry discarded.
  function automatic logic [7:0] f_csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  state_t     r_state, w_state;
  logic [7:0] r_dest, w_dest;
  logic [7:0] r_len, w_len;
  logic [7:0] r_cnt, w_cnt;
  logic [7:0] r_tx_data, w_tx_data;
  logic       r_tx_valid, w_tx_valid;
  logic       r_busy, w_busy;
  logic       r_in_ready, w_in_ready;
  logic       r_done, w_done;
`ifdef CMD_ENCODER_CHECKSUM_EN
  logic [7:0] r_acc, w_acc;
`endif

  logic w_tx_fire;
  logic w_in_fire;

  assign w_tx_fire = r_tx_valid & tx_ready;
  assign w_in_fire = r_in_ready & in_valid;

  assign busy     = r_busy;
  assign in_ready = r_in_ready;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign done     = r_done;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state    = r_state;
    w_dest     = r_dest;
    w_len      = r_len;
    w_cnt      = r_cnt;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_done     = 1'b0;
`ifdef CMD_ENCODER_CHECKSUM_EN
    w_acc      = r_acc;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state    = S_PREFIX;
          w_dest     = dest;
          w_len      = len;
          w_cnt      = len;
`ifdef CMD_ENCODER_CHECKSUM_EN
          w_acc      = 8'h00;
`endif
          w_tx_data  = PREFIX;
          w_tx_valid = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_PREFIX: begin
        if (w_tx_fire) begin
          w_state   = S_ADDR;
          w_tx_data = AST_ADDR;
        end else begin
          w_state = S_PREFIX;
        end
      end
      S_ADDR: begin
        if (w_tx_fire) begin
          w_state   = S_DEST;
          w_tx_data = r_dest;
        end else begin
          w_state = S_ADDR;
        end
      end
      S_DEST: begin
        if (w_tx_fire) begin
          w_state   = S_LEN;
          w_tx_data = r_len;
        end else begin
          w_state = S_DEST;
        end
      end
      S_LEN: begin
        if (w_tx_fire) begin
          if (r_cnt != 8'h00) begin
            w_state    = S_DATA;
            w_tx_valid = 1'b0;
          end else begin
`ifdef CMD_ENCODER_CHECKSUM_EN
            w_state    = S_CSUM;
            w_tx_data  = r_acc;
`else
            w_state    = S_IDLE;
            w_tx_valid = 1'b0;
            w_done     = 1'b1;
`endif
          end
        end else begin
          w_state = S_LEN;
        end
      end
      S_DATA: begin
        // Output register empty: load the next payload byte.
        if (w_in_fire) begin
          w_tx_data  = in_data;
          w_tx_valid = 1'b1;
          w_cnt      = r_cnt - 8'd1;
`ifdef CMD_ENCODER_CHECKSUM_EN
          w_acc      = f_csum_add(r_acc, in_data);
`endif
        end else if (w_tx_fire) begin
          if (r_cnt == 8'h00) begin
`ifdef CMD_ENCODER_CHECKSUM_EN
            w_state    = S_CSUM;
            w_tx_data  = r_acc;
`else
            w_state    = S_IDLE;
            w_tx_valid = 1'b0;
            w_done     = 1'b1;
`endif
          end else begin
            w_tx_valid = 1'b0;
          end
        end else begin
          w_state = S_DATA;
        end
      end
`ifdef CMD_ENCODER_CHECKSUM_EN
      S_CSUM: begin
        if (w_tx_fire) begin
          w_state    = S_IDLE;
          w_tx_valid = 1'b0;
          w_done     = 1'b1;
        end else begin
          w_state = S_CSUM;
        end
      end
`endif
      default: begin
        w_state    = S_IDLE;
        w_tx_valid = 1'b0;
      end
    endcase
    w_busy     = (w_state != S_IDLE);
    w_in_ready = (w_state == S_DATA) && !w_tx_valid;
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_dest     <= 8'h00;
      r_len      <= 8'h00;
      r_cnt      <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
`ifdef CMD_ENCODER_CHECKSUM_EN
      r_acc      <= 8'h00;
`endif
    end else begin
      r_state    <= w_state;
      r_dest     <= w_dest;
      r_len      <= w_len;
      r_cnt      <= w_cnt;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_busy     <= w_busy;
      r_in_ready <= w_in_ready;
      r_done     <= w_done;
`ifdef CMD_ENCODER_CHECKSUM_EN
      r_acc      <= w_acc;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
// Scoreboard bench for cmd_encoder. Expected bytes are queued when a packet
// is set up; a monitor pops and compares on every tx transfer. A source
// process feeds payload bytes honouring in_valid/in_ready.
module tb_cmd_encoder;

  logic       clk;
  logic       nrst;
  logic       start;
  logic [7:0] dest;
  logic [7:0] len;
  logic       busy;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  bit in_ready_seen = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] pl_q[$];

  cmd_encoder dut (
    .clk(clk), .nrst(nrst), .start(start), .dest(dest), .len(len),
    .busy(busy), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (nrst) begin
      if (done) done_cnt++;
      if (in_ready) in_ready_seen = 1'b1;
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("unexpected_tx_byte", {24'h0, tx_data}, 32'h100);
        else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Payload source: presents src_q[0] until handshaken.
  initial begin
    bit fire;
    in_valid = 1'b0;
    in_data  = 8'h00;
    forever begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Queue one packet's expected bytes and its payload from pl_q.
  task automatic load_pkt(input logic [7:0] d, input logic [7:0] l);
    logic [7:0] sum;
    sum = 8'h00;
    exp_q.push_back(8'hDD);
    exp_q.push_back(8'h01);
    exp_q.push_back(d);
    exp_q.push_back(l);
    foreach (pl_q[i]) begin
      exp_q.push_back(pl_q[i]);
      src_q.push_back(pl_q[i]);
      sum = sum + pl_q[i];
    end
`ifdef CMD_ENCODER_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    pl_q.delete();
  endtask

  task automatic issue_start(input logic [7:0] d, input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1; dest = d; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'h1);
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 400 && done_cnt < n; k++) @(posedge clk);
    #1;
    check("done_count", done_cnt, n);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit found;
    nrst = 1'b0; start = 1'b0; dest = 8'h00; len = 8'h00; tx_ready = 1'b1;
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data",  {24'h0, tx_data},  32'h0);
    check("rst_busy",     {31'h0, busy},     32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_done",     {31'h0, done},     32'h0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Basic packet: DD 01 04 06 01..06 [15]
    for (int i = 1; i <= 6; i++) pl_q.push_back(i[7:0]);
    load_pkt(8'h04, 8'h06);
    issue_start(8'h04, 8'h06);
    wait_done(1);
    check("idle_after_done", {31'h0, busy}, 32'h0);

    // Zero length: DD 01 04 00 [00], no in_ready
    in_ready_seen = 1'b0;
    load_pkt(8'h04, 8'h00);
    issue_start(8'h04, 8'h00);
    wait_done(2);
    check("len0_no_in_ready", {31'h0, in_ready_seen}, 32'h0);

    // Sink stall on payload byte 03
    for (int i = 1; i <= 6; i++) pl_q.push_back(i[7:0]);
    load_pkt(8'h04, 8'h06);
    issue_start(8'h04, 8'h06);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (tx_valid && tx_data == 8'h03) found = 1'b1;
    end
    check("stall_byte_found", {31'h0, found}, 32'h1);
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_tx_data",  {24'h0, tx_data},  32'h03);
      check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
      check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_done(3);

    // Checksum carry: FF 02 -> [01]
    pl_q.push_back(8'hFF);
    pl_q.push_back(8'h02);
    load_pkt(8'h04, 8'h02);
    issue_start(8'h04, 8'h02);
    wait_done(4);

    // start held through packet A: ignored while busy, re-accepted after done
    pl_q.push_back(8'hAA); pl_q.push_back(8'h55);
    load_pkt(8'h09, 8'h02);
    pl_q.push_back(8'h10); pl_q.push_back(8'h20); pl_q.push_back(8'h30);
    load_pkt(8'h07, 8'h03);
    @(posedge clk); #1;
    start = 1'b1; dest = 8'h09; len = 8'h02;
    @(posedge clk); #1;
    check("busy_pkt_a", {31'h0, busy}, 32'h1);
    dest = 8'h07; len = 8'h03;
    for (int k = 0; k < 400 && done_cnt < 5; k++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_pkt_a", done_cnt, 5);
    check("back_to_back_busy", {31'h0, busy}, 32'h1);
    wait_done(6);
    repeat (5) @(posedge clk);
    #1;
    check("no_extra_packet", {31'h0, busy}, 32'h0);

    // Reset after payload byte 04, then a fresh packet
    for (int i = 1; i <= 6; i++) pl_q.push_back(i[7:0]);
    load_pkt(8'h04, 8'h06);
    base = xfer_cnt;
    issue_start(8'h04, 8'h06);
    for (int k = 0; k < 200 && xfer_cnt < base + 8; k++) begin
      @(posedge clk); #2;
    end
    check("reached_byte_04", xfer_cnt - base, 8);
    nrst = 1'b0;
    #1;
    check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("mid_rst_busy",     {31'h0, busy},     32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    exp_q.delete();
    src_q.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {31'h0, tx_valid}, 32'h0);
    for (int i = 1; i <= 6; i++) pl_q.push_back(i[7:0]);
    load_pkt(8'h04, 8'h06);
    issue_start(8'h04, 8'h06);
    wait_done(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
